// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port-A ROM arbiter.
//   client_e : which requester owns the current transaction
//   state_e  : arbiter sequencer states
//   SD_AW    : SDRAM word-address width
package sdram_arb_pkg;

  localparam int SD_AW = 25;

  typedef enum logic [1:0] {
    CL_LD,
    CL_P,
    CL_S,
    CL_M
  } client_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    GAP
  } state_e;

endpackage

// File: rtl/rr_arbiter3.sv
// Combinational 3-way round-robin selector.
// Ports:
//   req [2:0] : request vector, bit0 = P, bit1 = S, bit2 = M
//   ptr [1:0] : rotation start, 0 = P, 1 = S, 2 = M
//   gnt [2:0] : one-hot grant, first requester at or after ptr
//   vld       : at least one request present
module rr_arbiter3 (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt,
  output logic       vld
);

  always_comb begin
    gnt = 3'b000;
    case (ptr)
      2'd1: begin
        if (req[1])      gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
      end
      2'd2: begin
        if (req[2])      gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
      end
      default: begin
        if (req[0])      gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
      end
    endcase
  end

  assign vld = |req;

endmodule

// File: rtl/sdram_rom_arbiter.sv
// Shares SDRAM controller port A between the ROM loader (writes) and the
// P-ROM, S-ROM and M-ROM fetch clients (reads). One transaction at a time;
// the loader always wins, the fetch clients rotate P -> S -> M. A watchdog
// abandons a transaction the controller never acknowledges.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   ld_req/ld_addr/ld_data   : loader write request (absolute address)
//   ld_ack                   : one-cycle write-done pulse
//   {p,s,m}_req/{p,s,m}_addr : fetch requests (word offset within region)
//   {p,s,m}_ack              : one-cycle pulse, rd_data valid that cycle
//   rd_data                  : last read word, shared by all fetch clients
//   timeout_err              : sticky watchdog-abort flag
//   sd_req/sd_we/sd_addr/sd_wdata/sd_ack/sd_rdata : controller port A
module sdram_rom_arbiter
  import sdram_arb_pkg::*;
#(
  parameter logic [SD_AW-1:0] BASE_P  = 25'h0000000,
  parameter logic [SD_AW-1:0] BASE_S  = 25'h0080000,
  parameter logic [SD_AW-1:0] BASE_M  = 25'h00A0000,
  parameter int               TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_req,
  input  logic [SD_AW-1:0] ld_addr,
  input  logic [15:0]      ld_data,
  output logic             ld_ack,
  input  logic             p_req,
  input  logic [23:0]      p_addr,
  output logic             p_ack,
  input  logic             s_req,
  input  logic [23:0]      s_addr,
  output logic             s_ack,
  input  logic             m_req,
  input  logic [23:0]      m_addr,
  output logic             m_ack,
  output logic [15:0]      rd_data,
  output logic             timeout_err,
  output logic             sd_req,
  output logic             sd_we,
  output logic [SD_AW-1:0] sd_addr,
  output logic [15:0]      sd_wdata,
  input  logic             sd_ack,
  input  logic [15:0]      sd_rdata
);

  // Watchdog fires on the TIMEOUT-th WAIT_ACK cycle without an ack.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_e           state_q, state_d;
  client_e          grant_q, grant_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [7:0]       wd_q, wd_d;

  logic             sd_req_d, sd_we_d;
  logic [SD_AW-1:0] sd_addr_d;
  logic [15:0]      sd_wdata_d, rd_data_d;
  logic             ld_ack_d, p_ack_d, s_ack_d, m_ack_d, terr_d;

  logic [2:0]       rr_gnt;
  logic             rr_vld;
  client_e          rr_client;
  logic [SD_AW-1:0] rr_addr;

  rr_arbiter3 u_rr (
    .req (({m_req, s_req, p_req})),
    .ptr (rr_ptr_q),
    .gnt (rr_gnt),
    .vld (rr_vld)
  );

  // Region base + zero-extended offset; the sum wraps modulo 2^25.
  always_comb begin
    rr_client = CL_P;
    rr_addr   = BASE_P + {1'b0, p_addr};
    if (rr_gnt[1]) begin
      rr_client = CL_S;
      rr_addr   = BASE_S + {1'b0, s_addr};
    end else if (rr_gnt[2]) begin
      rr_client = CL_M;
      rr_addr   = BASE_M + {1'b0, m_addr};
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    wd_d       = wd_q;
    sd_req_d   = sd_req;
    sd_we_d    = sd_we;
    sd_addr_d  = sd_addr;
    sd_wdata_d = sd_wdata;
    rd_data_d  = rd_data;
    terr_d     = timeout_err;
    ld_ack_d   = 1'b0;
    p_ack_d    = 1'b0;
    s_ack_d    = 1'b0;
    m_ack_d    = 1'b0;

    case (state_q)
      IDLE: begin
        sd_req_d = 1'b0;
        if (ld_req) begin
          grant_d    = CL_LD;
          sd_addr_d  = ld_addr;
          sd_we_d    = 1'b1;
          sd_wdata_d = ld_data;
          state_d    = ISSUE;
        end else if (rr_vld) begin
          grant_d    = rr_client;
          sd_addr_d  = rr_addr;
          sd_we_d    = 1'b0;
          sd_wdata_d = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        sd_req_d = 1'b1;
        wd_d     = '0;
        state_d  = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (sd_ack) begin
          sd_req_d = 1'b0;
          state_d  = GAP;
          // Pointer moves to the client after the one just served.
          case (grant_q)
            CL_LD: ld_ack_d = 1'b1;
            CL_P: begin
              p_ack_d   = 1'b1;
              rd_data_d = sd_rdata;
              rr_ptr_d  = 2'd1;
            end
            CL_S: begin
              s_ack_d   = 1'b1;
              rd_data_d = sd_rdata;
              rr_ptr_d  = 2'd2;
            end
            CL_M: begin
              m_ack_d   = 1'b1;
              rd_data_d = sd_rdata;
              rr_ptr_d  = 2'd0;
            end
          endcase
        end else if (wd_q == WD_LAST) begin
          // Abort without an ack: the client keeps requesting and is
          // simply arbitrated again.
          sd_req_d = 1'b0;
          terr_d   = 1'b1;
          state_d  = GAP;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      GAP: begin
        // req held low for a full cycle so the controller returns to idle
        // before the next transaction can be issued.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= CL_LD;
      rr_ptr_q    <= 2'd0;
      wd_q        <= '0;
      sd_req      <= 1'b0;
      sd_we       <= 1'b0;
      sd_addr     <= '0;
      sd_wdata    <= '0;
      rd_data     <= '0;
      timeout_err <= 1'b0;
      ld_ack      <= 1'b0;
      p_ack       <= 1'b0;
      s_ack       <= 1'b0;
      m_ack       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      wd_q        <= wd_d;
      sd_req      <= sd_req_d;
      sd_we       <= sd_we_d;
      sd_addr     <= sd_addr_d;
      sd_wdata    <= sd_wdata_d;
      rd_data     <= rd_data_d;
      timeout_err <= terr_d;
      ld_ack      <= ld_ack_d;
      p_ack       <= p_ack_d;
      s_ack       <= s_ack_d;
      m_ack       <= m_ack_d;
    end
  end

endmodule

// File: tb/tb_sdram_rom_arbiter.sv
module tb_sdram_rom_arbiter;

  localparam int CTL_LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_req, p_req, s_req, m_req;
  logic [24:0] ld_addr;
  logic [15:0] ld_data;
  logic [23:0] p_addr, s_addr, m_addr;
  logic        ld_ack, p_ack, s_ack, m_ack;
  logic [15:0] rd_data;
  logic        timeout_err;
  logic        sd_req, sd_we;
  logic [24:0] sd_addr;
  logic [15:0] sd_wdata;
  logic        sd_ack   = 1'b0;
  logic [15:0] sd_rdata = 16'h0000;

  // controller model controls
  logic        ctl_noack;
  logic [15:0] ctl_data;
  int          ctl_cnt  = 0;
  logic        ctl_done = 1'b0;

  int checks = 0;
  int errors = 0;
  int n_ld = 0, n_p = 0, n_s = 0, n_m = 0;

  always #5 clk = ~clk;

  sdram_rom_arbiter #(
    .BASE_P  (25'h0000000),
    .BASE_S  (25'h0080000),
    .BASE_M  (25'h1FFFFF0),
    .TIMEOUT (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ld_req      (ld_req),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_ack      (ld_ack),
    .p_req       (p_req),
    .p_addr      (p_addr),
    .p_ack       (p_ack),
    .s_req       (s_req),
    .s_addr      (s_addr),
    .s_ack       (s_ack),
    .m_req       (m_req),
    .m_addr      (m_addr),
    .m_ack       (m_ack),
    .rd_data     (rd_data),
    .timeout_err (timeout_err),
    .sd_req      (sd_req),
    .sd_we       (sd_we),
    .sd_addr     (sd_addr),
    .sd_wdata    (sd_wdata),
    .sd_ack      (sd_ack),
    .sd_rdata    (sd_rdata)
  );

  // Controller: acks CTL_LAT cycles after seeing req, once per request.
  always @(posedge clk) begin
    if (rst || !sd_req) begin
      ctl_cnt  <= 0;
      ctl_done <= 1'b0;
      sd_ack   <= 1'b0;
    end else if (ctl_done) begin
      sd_ack <= 1'b0;
    end else if (!ctl_noack) begin
      if (ctl_cnt == CTL_LAT - 1) begin
        sd_ack   <= 1'b1;
        sd_rdata <= ctl_data;
        ctl_done <= 1'b1;
      end
      ctl_cnt <= ctl_cnt + 1;
    end
  end

  // Ack-cycle counters (a one-cycle pulse adds exactly one).
  always @(posedge clk) begin
    if (ld_ack) n_ld <= n_ld + 1;
    if (p_ack)  n_p  <= n_p + 1;
    if (s_ack)  n_s  <= n_s + 1;
    if (m_ack)  n_m  <= n_m + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {m,s,p,ld} ack vector at the first negedge any ack is high;
  // zero if none appears within the bound.
  task automatic wait_ack(output logic [3:0] acks);
    acks = 4'b0000;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      acks = {m_ack, s_ack, p_ack, ld_ack};
      if (acks != 4'b0000) break;
    end
  endtask

  task automatic wait_sdreq();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sd_req) break;
    end
  endtask

  initial begin
    logic [3:0] a;
    logic [3:0] rr_exp [9];
    int n, c_ld, c_p, c_s, c_m;

    rst = 1'b1;
    ld_req = 1'b0; p_req = 1'b0; s_req = 1'b0; m_req = 1'b0;
    ld_addr = '0; ld_data = '0; p_addr = '0; s_addr = '0; m_addr = '0;
    ctl_noack = 1'b0; ctl_data = 16'h0000;
    repeat (3) @(negedge clk);

    chk("rst_sd_req", 32'(sd_req), 0);
    chk("rst_sd_we", 32'(sd_we), 0);
    chk("rst_sd_addr", 32'(sd_addr), 0);
    chk("rst_sd_wdata", 32'(sd_wdata), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_acks", 32'({m_ack, s_ack, p_ack, ld_ack}), 0);
    chk("rst_terr", 32'(timeout_err), 0);
    rst = 1'b0;

    // single P read
    c_p = n_p;
    p_addr = 24'h000123; ctl_data = 16'hBEEF; p_req = 1'b1;
    wait_ack(a);
    p_req = 1'b0;
    chk("rd_ack", 32'(a), 'b0010);
    chk("rd_addr", 32'(sd_addr), 'h0000123);
    chk("rd_we", 32'(sd_we), 0);
    chk("rd_data", 32'(rd_data), 'hBEEF);
    chk("rd_gap_req", 32'(sd_req), 0);
    @(negedge clk);
    chk("rd_ack_pulse", 32'(p_ack), 0);
    chk("rd_req_low", 32'(sd_req), 0);
    @(negedge clk);
    chk("rd_ack_cnt", 32'(n_p - c_p), 1);

    // watchdog on an S read
    c_s = n_s;
    s_addr = 24'h000044; ctl_noack = 1'b1; ctl_data = 16'hC0DE; s_req = 1'b1;
    wait_sdreq();
    n = 0;
    while (sd_req && n < 30) begin
      n++;
      @(negedge clk);
    end
    ctl_noack = 1'b0;
    chk("wd_req_len", 32'(n), 8);
    chk("wd_terr", 32'(timeout_err), 1);
    chk("wd_no_ack", 32'(n_s - c_s), 0);
    wait_ack(a);
    s_req = 1'b0;
    chk("wd_retry_ack", 32'(a), 'b0100);
    chk("wd_retry_addr", 32'(sd_addr), 'h0080044);
    chk("wd_retry_data", 32'(rd_data), 'hC0DE);
    chk("wd_terr_sticky", 32'(timeout_err), 1);
    @(negedge clk);
    chk("wd_ack_cnt", 32'(n_s - c_s), 1);

    // M address wrap: 1FFFFF0 + 20 -> 0000010
    m_addr = 24'h000020; ctl_data = 16'h1234; m_req = 1'b1;
    wait_ack(a);
    m_req = 1'b0;
    chk("wrap_ack", 32'(a), 'b1000);
    chk("wrap_addr", 32'(sd_addr), 'h0000010);
    chk("wrap_data", 32'(rd_data), 'h1234);
    @(negedge clk);

    // loader priority, then P, then S (pointer is at P here)
    ld_addr = 25'h1FFFFFF; ld_data = 16'h5A5A;
    p_addr = 24'h000010; s_addr = 24'h000020; ctl_data = 16'h1111;
    ld_req = 1'b1; p_req = 1'b1; s_req = 1'b1;
    wait_ack(a);
    ld_req = 1'b0;
    chk("ld_ack", 32'(a), 'b0001);
    chk("ld_we", 32'(sd_we), 1);
    chk("ld_addr", 32'(sd_addr), 'h1FFFFFF);
    chk("ld_wdata", 32'(sd_wdata), 'h5A5A);
    chk("ld_rd_keep", 32'(rd_data), 'h1234);
    wait_ack(a);
    p_req = 1'b0;
    chk("ld_then_p", 32'(a), 'b0010);
    chk("ld_p_addr", 32'(sd_addr), 'h0000010);
    chk("ld_p_we", 32'(sd_we), 0);
    chk("ld_p_data", 32'(rd_data), 'h1111);
    wait_ack(a);
    s_req = 1'b0;
    chk("ld_then_s", 32'(a), 'b0100);
    chk("ld_s_addr", 32'(sd_addr), 'h0080020);
    @(negedge clk);

    // reset during WAIT_ACK of an M read
    c_m = n_m;
    m_addr = 24'h000030; ctl_noack = 1'b1; m_req = 1'b1;
    wait_sdreq();
    @(negedge clk);
    chk("mr_pre_req", 32'(sd_req), 1);
    chk("mr_pre_addr", 32'(sd_addr), 'h0000020);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_sd_req", 32'(sd_req), 0);
    chk("mr_sd_addr", 32'(sd_addr), 0);
    chk("mr_sd_we", 32'(sd_we), 0);
    chk("mr_rd_data", 32'(rd_data), 0);
    chk("mr_terr", 32'(timeout_err), 0);
    chk("mr_acks", 32'({m_ack, s_ack, p_ack, ld_ack}), 0);
    rst = 1'b0; ctl_noack = 1'b0; ctl_data = 16'h7777;
    wait_ack(a);
    m_req = 1'b0;
    chk("mr_after_ack", 32'(a), 'b1000);
    chk("mr_after_addr", 32'(sd_addr), 'h0000020);
    chk("mr_after_data", 32'(rd_data), 'h7777);
    @(negedge clk);
    chk("mr_ack_cnt", 32'(n_m - c_m), 1);

    // round-robin with all three fetch clients held (pointer at P)
    rr_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000,
               4'b0010, 4'b0100, 4'b1000};
    c_ld = n_ld; c_p = n_p; c_s = n_s; c_m = n_m;
    ctl_data = 16'h2222;
    p_req = 1'b1; s_req = 1'b1; m_req = 1'b1;
    for (int k = 0; k < 9; k++) begin
      wait_ack(a);
      if (k == 8) begin
        p_req = 1'b0; s_req = 1'b0; m_req = 1'b0;
      end
      chk($sformatf("rr_grant_%0d", k), 32'(a), 32'(rr_exp[k]));
    end
    repeat (2) @(negedge clk);
    chk("rr_cnt_p", 32'(n_p - c_p), 3);
    chk("rr_cnt_s", 32'(n_s - c_s), 3);
    chk("rr_cnt_m", 32'(n_m - c_m), 3);
    chk("rr_cnt_ld", 32'(n_ld - c_ld), 0);
    chk("rr_idle_req", 32'(sd_req), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
